// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : Load/store unit between the datapath and a combinational-read,
//             synchronous-write word memory (dmem). Supports byte/halfword
//             loads (zero- or sign-extended) and sub-word stores via a
//             two-cycle read-modify-write. Little-endian: byte k of a word is
//             bits [8k+7:8k], selected by Addr[1:0].
//  Config   : ALIGN_CHECK_EN - when defined, misaligned half/word accesses
//             are suppressed and flagged on the sticky Fault_o output. When
//             undefined, low address bits are forced to alignment instead
//             and Fault_o is tied low.
//  Ports    : clk_i        rising-edge clock shared with dmem
//             reset_i      synchronous active-high reset
//             MemWrite_i   store request (held while Stall_o=1)
//             MemRead_i    load request
//             Size_i       00 byte, 01 half, 10/11 word
//             LdSigned_i   1 = sign-extend sub-word loads
//             Addr_i       byte address
//             WData_i      store data, right-aligned
//             RData_o      load result
//             Stall_o      hold pipeline this cycle
//             Fault_o      sticky misalignment flag
//             dA_o/dWD_o/dWE_o  dmem address / write data / write enable
//             dRD_i        dmem combinational read data
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          MemWrite_i,
   input  logic          MemRead_i,
   input  logic [1:0]    Size_i,
   input  logic          LdSigned_i,
   input  logic [AW-1:0] Addr_i,
   input  logic [DW-1:0] WData_i,
   output logic [DW-1:0] RData_o,
   output logic          Stall_o,
   output logic          Fault_o,
   output logic [AW-1:0] dA_o,
   output logic [DW-1:0] dWD_o,
   output logic          dWE_o,
   input  logic [DW-1:0] dRD_i
);

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_RMW_WR = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] merge_q, merge_d;
   logic [AW-1:0] addr_q, addr_d;

   logic          w_is_byte;
   logic          w_is_half;
   logic          w_is_word;
   logic [1:0]    w_lane;
   logic          w_misaligned;
   logic          w_store;
   logic          w_load;
   logic [DW-1:0] w_merge;
   logic [7:0]    w_ld_byte;
   logic [15:0]   w_ld_half;

   assign w_is_byte = (Size_i == 2'b00);
   assign w_is_half = (Size_i == 2'b01);
   assign w_is_word = Size_i[1];   // 11 is reserved and behaves as a word

`ifdef ALIGN_CHECK_EN
   assign w_lane       = Addr_i[1:0];
   assign w_misaligned = (w_is_half & Addr_i[0]) |
                         (w_is_word & (Addr_i[1:0] != 2'b00));
`else
   // Without checking, low address bits are simply ignored to keep accesses aligned.
   assign w_lane       = w_is_word ? 2'b00 :
                         w_is_half ? {Addr_i[1], 1'b0} : Addr_i[1:0];
   assign w_misaligned = 1'b0;
`endif

   // A simultaneous read and write request is a store.
   assign w_store = MemWrite_i & ~w_misaligned;
   assign w_load  = MemRead_i & ~MemWrite_i & ~w_misaligned;

   // ---------------- load extraction ----------------
   always_comb begin
      w_ld_byte = 8'h00;
      case (w_lane)
         2'd0:    w_ld_byte = dRD_i[7:0];
         2'd1:    w_ld_byte = dRD_i[15:8];
         2'd2:    w_ld_byte = dRD_i[23:16];
         default: w_ld_byte = dRD_i[31:24];
      endcase
      w_ld_half = w_lane[1] ? dRD_i[31:16] : dRD_i[15:0];

      RData_o = '0;
      if (w_load) begin
         if (w_is_byte) begin
            RData_o = {{24{LdSigned_i & w_ld_byte[7]}}, w_ld_byte};
         end else if (w_is_half) begin
            RData_o = {{16{LdSigned_i & w_ld_half[15]}}, w_ld_half};
         end else begin
            RData_o = dRD_i;
         end
      end
   end

   // ---------------- store lane merge ----------------
   // The current memory word with the addressed lane(s) overwritten.
   always_comb begin
      w_merge = dRD_i;
      if (w_is_byte) begin
         case (w_lane)
            2'd0:    w_merge[7:0]   = WData_i[7:0];
            2'd1:    w_merge[15:8]  = WData_i[7:0];
            2'd2:    w_merge[23:16] = WData_i[7:0];
            default: w_merge[31:24] = WData_i[7:0];
         endcase
      end else if (w_lane[1]) begin
         w_merge[31:16] = WData_i[15:0];
      end else begin
         w_merge[15:0]  = WData_i[15:0];
      end
   end

   // ---------------- control ----------------
   always_comb begin
      state_d = state_q;
      merge_d = merge_q;
      addr_d  = addr_q;
      dA_o    = Addr_i;
      dWD_o   = WData_i;
      dWE_o   = 1'b0;
      Stall_o = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (w_store) begin
               if (w_is_word) begin
                  dWE_o = 1'b1;
               end else begin
                  // Read phase: capture the merged word, write it next cycle.
                  Stall_o = 1'b1;
                  merge_d = w_merge;
                  addr_d  = Addr_i;
                  state_d = S_RMW_WR;
               end
            end
         end
         S_RMW_WR: begin
            dA_o    = addr_q;
            dWD_o   = merge_q;
            dWE_o   = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Reset suppresses any write, including an in-flight RMW write phase.
      if (reset_i) begin
         dWE_o   = 1'b0;
         Stall_o = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         merge_q <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         merge_q <= merge_d;
         addr_q  <= addr_d;
      end
   end

`ifdef ALIGN_CHECK_EN
   logic fault_q;

   // Detection only happens in IDLE where requests are accepted.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         fault_q <= 1'b0;
      end else if ((state_q == S_IDLE) && w_misaligned && (MemWrite_i | MemRead_i)) begin
         fault_q <= 1'b1;
      end
   end

   assign Fault_o = fault_q;
`else
   assign Fault_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_unit
//  Purpose  : Self-checking bench for mem_access_unit with a behavioural
//             word memory, directed vector table, multi-cycle corner
//             sequences and randomized operations against a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

`ifdef ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        MemWrite, MemRead, LdSigned;
   logic [1:0]  Size;
   logic [31:0] Addr, WData, RData, dA, dWD, dRD;
   logic        Stall, Fault, dWE;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.AW(32), .DW(32)) dut (
      .clk_i      (clk),
      .reset_i    (rst),
      .MemWrite_i (MemWrite),
      .MemRead_i  (MemRead),
      .Size_i     (Size),
      .LdSigned_i (LdSigned),
      .Addr_i     (Addr),
      .WData_i    (WData),
      .RData_o    (RData),
      .Stall_o    (Stall),
      .Fault_o    (Fault),
      .dA_o       (dA),
      .dWD_o      (dWD),
      .dWE_o      (dWE),
      .dRD_i      (dRD)
   );

   // ---------------- behavioural dmem ----------------
   logic [31:0] mem [0:63];
   logic        pl_we = 1'b0;
   logic [5:0]  pl_idx = '0;
   logic [31:0] pl_data = '0;

   always @(posedge clk) begin
      if (dWE)        mem[dA[7:2]] <= dWD;
      else if (pl_we) mem[pl_idx]  <= pl_data;
   end
   assign dRD = mem[dA[7:2]];

   // ---------------- reference model ----------------
   logic [31:0] ref_mem [0:63];
   bit          ref_fault;

   function automatic bit ref_misaligned(input logic [1:0] sz, input logic [7:0] a);
      if (!ALIGN)       return 1'b0;
      if (sz == 2'b01)  return a[0];
      if (sz[1])        return (a[1:0] != 2'b00);
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                            input logic sgn, input logic [7:0] a);
      int          sh;
      logic [31:0] v;
      if (sz == 2'b00) begin
         sh = 8 * int'(a[1:0]);
         v  = (w >> sh) & 32'h0000_00FF;
         if (sgn && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'b01) begin
         sh = 16 * int'(a[1]);
         v  = (w >> sh) & 32'h0000_FFFF;
         if (sgn && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [7:0] a, input logic [31:0] wd);
      int          sh;
      logic [31:0] mask;
      if (sz == 2'b00) begin
         sh   = 8 * int'(a[1:0]);
         mask = 32'h0000_00FF << sh;
         return (w & ~mask) | ((wd & 32'h0000_00FF) << sh);
      end else if (sz == 2'b01) begin
         sh   = 16 * int'(a[1]);
         mask = 32'h0000_FFFF << sh;
         return (w & ~mask) | ((wd & 32'h0000_FFFF) << sh);
      end
      return wd;
   endfunction

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [5:0] idx, input logic [31:0] data);
      pl_we   = 1'b1;
      pl_idx  = idx;
      pl_data = data;
      @(posedge clk);
      #1;
      pl_we = 1'b0;
      ref_mem[idx] = data;
   endtask

   // Issues one request and holds it while Stall is high.
   // rdata is sampled in the first cycle; cycles counts clock edges consumed.
   task automatic do_op(input logic wr, input logic rd, input logic [1:0] sz,
                        input logic sgn, input logic [7:0] a, input logic [31:0] wd,
                        output logic [31:0] rdata, output int cycles, output bit we_seen);
      bit stl;
      MemWrite = wr;
      MemRead  = rd;
      Size     = sz;
      LdSigned = sgn;
      Addr     = {24'h0, a};
      WData    = wd;
      cycles   = 0;
      we_seen  = 1'b0;
      rdata    = '0;
      forever begin
         @(negedge clk);
         if (cycles == 0) rdata = RData;
         stl = Stall;
         if (dWE) we_seen = 1'b1;
         @(posedge clk);
         #1;
         cycles++;
         if (!stl) break;
         if (cycles >= 4) begin
            n_checks++;
            n_err++;
            $display("FAIL stall_timeout: got %0d cycles expected at most 2", cycles);
            break;
         end
      end
      MemWrite = 1'b0;
      MemRead  = 1'b0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        wr;
      logic        rd;
      logic [1:0]  sz;
      logic        sgn;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] init;
      logic [31:0] exp_rdata;
      logic [31:0] exp_word;
      int          exp_cyc;
   } vec_t;

   vec_t vecs [16];

   initial begin
      logic [31:0] rd_v;
      int          cyc, tot;
      bit          we;
      logic [31:0] old_w, new_w, exp_rd;
      bit          mis;
      int          r;
      logic        wr_r, rd_r, sgn_r;
      logic [1:0]  sz_r;
      logic [7:0]  a_r;
      logic [31:0] wd_r;

      vecs[0]  = '{1'b1, 1'b0, 2'b10, 1'b0, 8'h08, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 32'hDEADBEEF, 1};
      vecs[1]  = '{1'b0, 1'b1, 2'b10, 1'b0, 8'h08, 32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1};
      vecs[2]  = '{1'b1, 1'b0, 2'b00, 1'b0, 8'h06, 32'h000000AA, 32'h11223344, 32'h00000000, 32'h11AA3344, 2};
      vecs[3]  = '{1'b0, 1'b1, 2'b00, 1'b1, 8'h0E, 32'h00000000, 32'h80FF7F01, 32'hFFFFFFFF, 32'h80FF7F01, 1};
      vecs[4]  = '{1'b0, 1'b1, 2'b00, 1'b0, 8'h0E, 32'h00000000, 32'h80FF7F01, 32'h000000FF, 32'h80FF7F01, 1};
      vecs[5]  = '{1'b0, 1'b1, 2'b01, 1'b1, 8'h0E, 32'h00000000, 32'h80FF7F01, 32'hFFFF80FF, 32'h80FF7F01, 1};
      vecs[6]  = '{1'b0, 1'b1, 2'b01, 1'b1, 8'h0C, 32'h00000000, 32'h80FF7F01, 32'h00007F01, 32'h80FF7F01, 1};
      vecs[7]  = '{1'b0, 1'b1, 2'b01, 1'b0, 8'h0E, 32'h00000000, 32'h80FF7F01, 32'h000080FF, 32'h80FF7F01, 1};
      vecs[8]  = '{1'b0, 1'b1, 2'b00, 1'b1, 8'h0F, 32'h00000000, 32'h80FF7F01, 32'hFFFFFF80, 32'h80FF7F01, 1};
      vecs[9]  = '{1'b0, 1'b1, 2'b00, 1'b1, 8'h0D, 32'h00000000, 32'h80FF7F01, 32'h0000007F, 32'h80FF7F01, 1};
      vecs[10] = '{1'b1, 1'b0, 2'b01, 1'b0, 8'h1A, 32'h00001234, 32'hAABBCCDD, 32'h00000000, 32'h1234CCDD, 2};
      vecs[11] = '{1'b1, 1'b1, 2'b00, 1'b0, 8'h21, 32'h0000005A, 32'h00000000, 32'h00000000, 32'h00005A00, 2};
      vecs[12] = '{1'b1, 1'b0, 2'b11, 1'b0, 8'h24, 32'h01020304, 32'hFFFFFFFF, 32'h00000000, 32'h01020304, 1};
      vecs[13] = '{1'b0, 1'b0, 2'b00, 1'b0, 8'h28, 32'h00000000, 32'h77777777, 32'h00000000, 32'h77777777, 1};
      vecs[14] = '{1'b1, 1'b0, 2'b00, 1'b0, 8'h2C, 32'hFFFFFF3C, 32'h00000000, 32'h00000000, 32'h0000003C, 2};
      vecs[15] = '{1'b1, 1'b0, 2'b00, 1'b0, 8'h33, 32'h000000C3, 32'h12345678, 32'h00000000, 32'hC3345678, 2};

      // ---- reset: a sub-word store request must be ignored ----
      rst = 1'b1; MemWrite = 1'b1; MemRead = 1'b0; Size = 2'b00; LdSigned = 1'b0;
      Addr = 32'h4; WData = 32'hFF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_dWE",   {31'h0, dWE},   32'h0);
      check("reset_Stall", {31'h0, Stall}, 32'h0);
      @(posedge clk);
      #1;
      check("reset_Fault", {31'h0, Fault}, 32'h0);
      rst = 1'b0; MemWrite = 1'b0;

      for (int i = 0; i < 64; i++) preload(6'(i), 32'h0);

      // ---- table ----
      for (int i = 0; i < 16; i++) begin
         preload(vecs[i].addr[7:2], vecs[i].init);
         do_op(vecs[i].wr, vecs[i].rd, vecs[i].sz, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
               rd_v, cyc, we);
         check($sformatf("vec%0d_rdata", i),  rd_v, vecs[i].exp_rdata);
         check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
         check($sformatf("vec%0d_dWE", i),    {31'h0, we}, {31'h0, vecs[i].wr});
         check($sformatf("vec%0d_word", i),   mem[vecs[i].addr[7:2]], vecs[i].exp_word);
      end

      // ---- back-to-back byte stores ----
      preload(6'd0, 32'h0);
      tot = 0;
      do_op(1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 32'h01, rd_v, cyc, we); tot += cyc;
      do_op(1'b1, 1'b0, 2'b00, 1'b0, 8'h01, 32'h02, rd_v, cyc, we); tot += cyc;
      do_op(1'b1, 1'b0, 2'b00, 1'b0, 8'h02, 32'h03, rd_v, cyc, we); tot += cyc;
      check("b2b_cycles", 32'(tot), 32'd6);
      check("b2b_word",   mem[0], 32'h00030201);

      // ---- reset during the RMW write phase ----
      preload(6'd4, 32'h55667788);
      MemWrite = 1'b1; MemRead = 1'b0; Size = 2'b01; LdSigned = 1'b0;
      Addr = 32'h12; WData = 32'hBEEF;
      @(negedge clk);
      check("rmwrst_stall1", {31'h0, Stall}, 32'h1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("rmwrst_dWE",   {31'h0, dWE},   32'h0);
      check("rmwrst_stall", {31'h0, Stall}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0; MemWrite = 1'b0;
      @(negedge clk);
      check("rmwrst_word", mem[4], 32'h55667788);
      check("rmwrst_idle_stall", {31'h0, Stall}, 32'h0);
      @(posedge clk);
      #1;
      // FSM must be back in IDLE: a fresh byte store takes exactly 2 cycles.
      do_op(1'b1, 1'b0, 2'b00, 1'b0, 8'h11, 32'h99, rd_v, cyc, we);
      check("rmwrst_next_cycles", 32'(cyc), 32'd2);
      check("rmwrst_next_word", mem[4], 32'h55669988);

      // ---- misaligned word store ----
      preload(6'd1, 32'h13579BDF);
      check("mis_fault_before", {31'h0, Fault}, 32'h0);
      do_op(1'b1, 1'b0, 2'b10, 1'b0, 8'h05, 32'hCAFEF00D, rd_v, cyc, we);
      check("mis_cycles", 32'(cyc), 32'd1);
`ifdef ALIGN_CHECK_EN
      check("mis_word",  mem[1], 32'h13579BDF);
      check("mis_dWE",   {31'h0, we}, 32'h0);
      check("mis_fault", {31'h0, Fault}, 32'h1);
      repeat (3) @(posedge clk);
      #1;
      check("mis_fault_sticky", {31'h0, Fault}, 32'h1);
`else
      check("mis_word",  mem[1], 32'hCAFEF00D);
      check("mis_dWE",   {31'h0, we}, 32'h1);
      check("mis_fault", {31'h0, Fault}, 32'h0);
`endif
      ref_fault = ALIGN;

      // ---- randomized operations against the reference model ----
      for (int i = 0; i < 64; i++) preload(6'(i), $urandom);
      for (int i = 0; i < 300; i++) begin
         r     = int'($urandom_range(0, 9));
         wr_r  = (r < 4) || (r == 8);
         rd_r  = ((r >= 4) && (r < 8)) || (r == 8);
         sz_r  = 2'($urandom_range(0, 3));
         sgn_r = 1'($urandom_range(0, 1));
         a_r   = 8'($urandom_range(0, 63));
         wd_r  = $urandom;
         old_w = ref_mem[a_r[7:2]];
         mis   = ref_misaligned(sz_r, a_r) && (wr_r || rd_r);
         exp_rd = (rd_r && !wr_r && !mis) ? ref_load(old_w, sz_r, sgn_r, a_r) : 32'h0;
         new_w  = (wr_r && !mis) ? ref_store(old_w, sz_r, a_r, wd_r) : old_w;
         if (mis) ref_fault = 1'b1;
         do_op(wr_r, rd_r, sz_r, sgn_r, a_r, wd_r, rd_v, cyc, we);
         check($sformatf("rand%0d_rdata", i), rd_v, exp_rd);
         check($sformatf("rand%0d_cycles", i), 32'(cyc),
               (wr_r && !mis && (sz_r[1] == 1'b0)) ? 32'd2 : 32'd1);
         check($sformatf("rand%0d_dWE", i), {31'h0, we}, {31'h0, (wr_r && !mis)});
         check($sformatf("rand%0d_word", i), mem[a_r[7:2]], new_w);
         ref_mem[a_r[7:2]] = new_w;
      end
      check("final_fault", {31'h0, Fault}, {31'h0, ref_fault});

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire
